// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources in ID.
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_memtoreg,
    output logic             lu_hazard
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit   = id_use_rs1 && (id_rs1 == ex_rd);
        rs2_hit   = id_use_rs2 && (id_rs2 == ex_rd);
        // x0 never carries a value, so a load to x0 cannot create a hazard
        lu_hazard = ex_memtoreg && (ex_rd != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing: memory freeze, load-use bubble, redirect squash,
// stall/flush counters and sticky memory-timeout flag.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_memtoreg,
    input  logic             ex_redirect,
    input  logic             mem_memtoreg,
    input  logic [3:0]       mem_memwrite,
    input  logic             dmem_ready,
    output logic             dmem_req,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;
    logic               mem_err_q, mem_err_d;

    logic mem_op;
    logic freeze;
    logic lu_hazard;
    logic lu_stall;
    logic redir;

    hazard_detect u_hazard (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_rd       (ex_rd),
        .ex_memtoreg (ex_memtoreg),
        .lu_hazard   (lu_hazard)
    );

    always_comb begin
        mem_op   = mem_memtoreg || (mem_memwrite != '0);
        freeze   = mem_op && !dmem_ready;
        redir    = !freeze && ex_redirect;
        lu_stall = !freeze && !ex_redirect && lu_hazard;
    end

    always_comb begin
        dmem_req      = 1'b0;
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_en     = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            dmem_req = mem_op;
            unique case (1'b1)
                freeze: begin
                    mem_wb_bubble = 1'b1;
                end
                redir: begin
                    pc_en       = 1'b1;
                    if_id_en    = 1'b1;
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                lu_stall: begin
                    id_ex_en    = 1'b1;
                    ex_mem_en   = 1'b1;
                    mem_wb_en   = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_en     = 1'b1;
                    if_id_en  = 1'b1;
                    id_ex_en  = 1'b1;
                    ex_mem_en = 1'b1;
                    mem_wb_en = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        mem_err_d   = mem_err_q;
        stall_cnt_d = stall_cnt_q + CNT_W'(freeze || lu_stall);
        flush_cnt_d = flush_cnt_q + CNT_W'(redir);
        unique case (state_q)
            RUN: begin
                if (freeze) begin
                    state_d = WAIT;
                    wcnt_d  = '0;
                end
            end
            WAIT: begin
                if (dmem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_MAX) begin
                    // Saturated: flag the hang but keep waiting
                    mem_err_d = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wcnt_q      <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mem_err_q   <= mem_err_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign mem_err   = mem_err_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage RISC-V core. It drives the enable and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the PC. It freezes the whole pipeline while a multi-cycle data-memory access in MEM is outstanding. It inserts a one-cycle bubble on load-use hazards and squashes the two younger stages on a taken branch or jump resolved in EX. It also maintains stall/flush performance counters and a sticky memory-timeout error.

## Interface
- TIMEOUT, 64: maximum MEM_WAIT cycles before `mem_err` sets; must be ≥ 1.
- CNT_W, 32: width of the performance counters.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  the instruction in ID reads rs1 / rs2.
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memtoreg  in  1  the instruction in EX is a load.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- mem_memtoreg  in  1  EX/MEM holds a load.
- mem_memwrite  in  4  EX/MEM byte-write mask; nonzero means store.
- dmem_ready  in  1  data memory completes the current access this cycle.
- dmem_req  out  1  data-memory request strobe.
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush  out  1 each  load a NOP/bubble with all control bits zero.
- mem_wb_bubble  out  1  MEM/WB receives a bubble with regwrite=0.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.
- mem_err  out  1  sticky timeout flag.

## Operation
- Define `mem_op` as `mem_memtoreg | (mem_memwrite != 0)`.
- Define `lu_hazard` as `ex_memtoreg & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd))`.
- FSM states:
  - RUN (reset state). If `mem_op` is 1 and `dmem_ready` is 0, go to WAIT. Otherwise stay in RUN.
  - WAIT. If `dmem_ready` is 1, go to RUN. Otherwise stay in WAIT.
- `dmem_req = mem_op & ~rst`, in both states. It is held high continuously until `dmem_ready`. Zero-wait completion (ready in the same cycle as the request) is legal.
- Freeze condition: `mem_op & ~dmem_ready`, in either state.
  - All five enables are 0.
  - `mem_wb_bubble = 1`, so no duplicate writeback occurs.
  - No flushes are asserted.
- Otherwise, priority applies: redirect beats load-use.
  - `ex_redirect`: all enables 1, `if_id_flush = id_ex_flush = 1`. A load-use hazard in the same cycle is ignored because the ID instruction is squashed.
  - `lu_hazard`: `pc_en = if_id_en = 0`, `id_ex_flush = 1`, `id_ex_en = ex_mem_en = mem_wb_en = 1`.
  - Neither: all enables 1, no flushes.
- A redirect or hazard present while frozen is not lost. EX and ID are held, so the condition is acted on in the release cycle.
- Counters:
  - `stall_cnt` increments by 1 in every cycle with freeze or load-use stall.
  - `flush_cnt` increments by 1 in every unfrozen redirect cycle.
  - Both wrap modulo 2^CNT_W.
- Timeout: a `wcnt` register counts WAIT cycles.
  - It is cleared on entry to WAIT and on leaving WAIT.
  - When `wcnt` reaches TIMEOUT−1 while still waiting, `mem_err` sets.
  - `mem_err` clears only on `rst`; the FSM keeps waiting.
  - `wcnt` saturates and does not wrap.

## Timing
- While `rst` is high:
  - state = RUN; `wcnt`, `stall_cnt`, `flush_cnt` = 0; `mem_err` = 0.
  - All enables = 0, all flush/bubble outputs = 0, `dmem_req` = 0.
- Reset asserted mid-WAIT aborts the access. `dmem_req` drops asynchronously with `rst`.
- All control outputs are combinational from the current state and inputs, with zero latency. Pipeline registers sample them at the same edge as their data.
- Load-use costs exactly 1 bubble cycle. A redirect costs 2 squashed instructions. An N-cycle memory access (ready in the Nth cycle) costs N−1 freeze cycles.
- Registered state (FSM, counters, `mem_err`) updates on posedge `clk`. Counter values are visible the cycle after the event.

## Structure
- Shared package `pipe_pkg`:
  - state enum {RUN, WAIT};
  - NOP instruction constant 32'h00000013, for the flush encoding used by the pipeline registers;
  - register-index width 5.
- One sub-module, `hazard_detect`: the combinational `lu_hazard` compare, reusable by a future forwarding unit.
- FSM, timeout counter and performance counters live in `pipe_ctrl`.

## Test plan
- Independent instructions, `dmem_ready` tied 1, store in MEM → all enables 1, `dmem_req` = 1 for exactly 1 cycle, state stays RUN, `stall_cnt` = 0.
- Load x5 in EX, `add x6,x5,x1` in ID → 1 cycle with `pc_en = if_id_en = 0` and `id_ex_flush = 1`, `stall_cnt` = 1. Repeat with `ex_rd` = 0 → no stall.
- Load in MEM, `dmem_ready` asserted on the 4th request cycle → 3 freeze cycles with all enables 0, state WAIT for 3 cycles, `stall_cnt` = 3, no repeated request after release.
- `ex_redirect` together with `lu_hazard` → both flushes = 1, `pc_en` = 1, `flush_cnt` = 1, `stall_cnt` unchanged. Repeat while frozen → flush occurs only in the release cycle.
- TIMEOUT=4, `dmem_ready` held 0 → `mem_err` rises after 4 WAIT cycles and stays high after a later ready. Assert `rst` mid-WAIT → `dmem_req` = 0 immediately, state RUN, counters 0.
